// File: rtl/grad_accumulator_pkg.sv
// Shared types for the dW/db gradient path: element data type, layer sizes,
// accumulator FSM states and a counter-width helper.
package grad_accumulator_pkg;

   localparam int DATA_W = 16;
   typedef logic signed [DATA_W-1:0] data_type;

   localparam int L1 = 4;
   localparam int L2 = 8;
   localparam int L3 = 8;
   localparam int L4 = 3;

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } acc_state_e;

   // Counter width that stays at least 1 bit when the range collapses to one value.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/grad_acc_ctrl.sv
// Batch sequencing for grad_accumulator: ACCUM/DRAIN FSM, element index,
// sample counter, handshake flags and the sticky framing error.
module grad_acc_ctrl
   import grad_accumulator_pkg::*;
#(
   parameter int M          = 5,
   parameter int N          = 3,
   parameter int BATCH_LOG2 = 2,
   parameter int IDX_W      = cnt_w(M*N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic             out_last,
   output logic             err,
   output logic [IDX_W-1:0] idx,
   output logic             first_smp
);

   localparam int SMP_W = (BATCH_LOG2 > 0) ? BATCH_LOG2 : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M*N-1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((2**BATCH_LOG2)-1);
   localparam logic [SMP_W-1:0] SMP_ONE  = SMP_W'(1);

   acc_state_e       state;
   logic [SMP_W-1:0] smp;

   assign first_smp = (smp == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         idx       <= '0;
         smp       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else if (clear) begin
         state     <= ACCUM;
         idx       <= '0;
         smp       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (in_last != (idx == IDX_LAST))
                     err <= 1'b1;
                  if (idx == IDX_LAST) begin
                     idx <= '0;
                     if (smp == SMP_LAST) begin
                        state     <= DRAIN;
                        smp       <= '0;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_last  <= (IDX_LAST == '0);
                     end else begin
                        smp <= smp + SMP_ONE;
                     end
                  end else begin
                     idx <= idx + IDX_ONE;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= ACCUM;
                     idx       <= '0;
                     smp       <= '0;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     idx      <= idx + IDX_ONE;
                     // Look one element ahead so out_last lines up with the new idx.
                     out_last <= ((idx + IDX_ONE) == IDX_LAST);
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: rtl/grad_accumulator.sv
// Mini-batch gradient accumulator: sums 2^BATCH_LOG2 per-sample tensors in
// place and streams out the floor-averaged tensor, row-major.
module grad_accumulator
   import grad_accumulator_pkg::*;
#(
   parameter int M          = 5,
   parameter int N          = 3,
   parameter int BATCH_LOG2 = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     clear,
   input  logic     in_valid,
   output logic     in_ready,
   input  data_type in_data,
   input  logic     in_last,
   output logic     out_valid,
   input  logic     out_ready,
   output data_type out_data,
   output logic     out_last,
   output logic     err
);

   localparam int ACC_W = DATA_W + BATCH_LOG2;
   localparam int IDX_W = cnt_w(M*N);

   typedef logic signed [ACC_W-1:0] acc_t;

   logic [IDX_W-1:0] idx;
   logic             first_smp;
   logic             in_fire;
   acc_t             acc [M*N];
   acc_t             acc_rd;

   grad_acc_ctrl #(
      .M          (M),
      .N          (N),
      .BATCH_LOG2 (BATCH_LOG2),
      .IDX_W      (IDX_W)
   ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .err       (err),
      .idx       (idx),
      .first_smp (first_smp)
   );

   assign in_fire = in_valid && in_ready && !clear;

   // No reset: the first sample of every batch overwrites the entry.
   always_ff @(posedge clk) begin
      if (in_fire)
         acc[idx] <= first_smp ? acc_t'(in_data) : acc[idx] + acc_t'(in_data);
   end

   assign acc_rd   = acc[idx];
   assign out_data = out_valid ? data_type'(acc_rd >>> BATCH_LOG2) : '0;

endmodule

// File: tb/tb_grad_accumulator.sv
// Directed bench for grad_accumulator: M=2,N=2,BATCH_LOG2=1 main instance plus
// an M=1,N=1,BATCH_LOG2=2 instance for the single-element boundary.
module tb_grad_accumulator;
   import grad_accumulator_pkg::*;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   logic     clear = 1'b0;
   logic     in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   data_type in_data = '0;
   logic     in_ready, out_valid, out_last, err;
   data_type out_data;

   logic     clear2 = 1'b0;
   logic     in_valid2 = 1'b0, in_last2 = 1'b0, out_ready2 = 1'b0;
   data_type in_data2 = '0;
   logic     in_ready2, out_valid2, out_last2, err2;
   data_type out_data2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   grad_accumulator #(.M(2), .N(2), .BATCH_LOG2(1)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .err(err)
   );

   grad_accumulator #(.M(1), .N(1), .BATCH_LOG2(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
      .err(err2)
   );

   task automatic send(input data_type d, input logic last);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin @(negedge clk); n++; end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
      end
      in_valid = 1'b1; in_data = d; in_last = last;
      @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic recv(output data_type d, output logic l, output logic ok);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      ok = out_valid; d = out_data; l = out_last;
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   task automatic send_sample(input data_type s0, input data_type s1,
                              input data_type s2, input data_type s3);
      send(s0, 1'b0); send(s1, 1'b0); send(s2, 1'b0); send(s3, 1'b1);
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
          out_data !== 16'sd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rdy=%0b vld=%0b last=%0b data=%0d err=%0b, required all 0",
                  in_ready, out_valid, out_last, out_data, err);
      end
      checks++;
      if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0 || err2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state2: rdy=%0b vld=%0b err=%0b, required 0", in_ready2, out_valid2, err2);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%0b vld=%0b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic;
      data_type exp [4] = '{16'sd2, 16'sd3, 16'sd4, 16'sd5};
      data_type d; logic l, ok;
      send_sample(16'sd1, 16'sd2, 16'sd3, 16'sd4);
      send(16'sd3, 1'b0); send(16'sd4, 1'b0); send(16'sd5, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_early_valid: out_valid=%0b, required 0", out_valid);
      end
      send(16'sd6, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency: vld=%0b rdy=%0b, required 1/0", out_valid, in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         recv(d, l, ok);
         checks++;
         if (!ok || d !== exp[i] || l !== (i == 3)) begin
            errors++;
            $display("FAIL basic_out[%0d]: vld=%0b data=%0d last=%0b, required %0d/%0b",
                     i, ok, d, l, exp[i], (i == 3));
         end
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_after_drain: rdy=%0b vld=%0b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_floor;
      data_type exp [4] = '{-16'sd2, -16'sd1, 16'sd3, 16'sd0};
      data_type d; logic l, ok;
      send_sample(-16'sd3, -16'sd1, 16'sd7, 16'sd0);
      send_sample(16'sd0, 16'sd0, 16'sd0, 16'sd1);
      for (int i = 0; i < 4; i++) begin
         recv(d, l, ok);
         checks++;
         if (!ok || d !== exp[i] || l !== (i == 3)) begin
            errors++;
            $display("FAIL floor_out[%0d]: data=%0d last=%0b, required %0d/%0b", i, d, l, exp[i], (i == 3));
         end
      end
   endtask

   task automatic test_extremes;
      data_type ext [2] = '{16'sh7fff, 16'sh8000};
      data_type d; logic l, ok;
      for (int b = 0; b < 2; b++) begin
         send_sample(ext[b], ext[b], ext[b], ext[b]);
         send_sample(ext[b], ext[b], ext[b], ext[b]);
         for (int i = 0; i < 4; i++) begin
            recv(d, l, ok);
            checks++;
            if (!ok || d !== ext[b]) begin
               errors++;
               $display("FAIL extreme_out[%0d][%0d]: data=%0d, required %0d", b, i, d, ext[b]);
            end
         end
      end
   endtask

   task automatic test_stall;
      data_type exp [4] = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
      data_type d; logic l, ok;
      send_sample(16'sd10, 16'sd20, 16'sd30, 16'sd40);
      send_sample(16'sd10, 16'sd20, 16'sd30, 16'sd40);
      recv(d, l, ok);
      checks++;
      if (!ok || d !== exp[0]) begin
         errors++; $display("FAIL stall_first: data=%0d, required %0d", d, exp[0]);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp[1] || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: vld=%0b data=%0d last=%0b rdy=%0b, required 1/%0d/0/0",
                     c, out_valid, out_data, out_last, in_ready, exp[1]);
         end
      end
      for (int i = 1; i < 4; i++) begin
         recv(d, l, ok);
         checks++;
         if (!ok || d !== exp[i] || l !== (i == 3)) begin
            errors++;
            $display("FAIL stall_out[%0d]: data=%0d last=%0b, required %0d/%0b", i, d, l, exp[i], (i == 3));
         end
      end
   endtask

   task automatic test_clear;
      data_type d; logic l, ok;
      send_sample(16'sd5, 16'sd5, 16'sd5, 16'sd5);
      send(16'sd7, 1'b0); send(16'sd7, 1'b0); send(16'sd7, 1'b0);
      // Clear coincides with a valid beat that must be dropped.
      @(negedge clk); clear = 1'b1; in_valid = 1'b1; in_data = 16'sd100; in_last = 1'b0;
      @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
      send_sample(16'sd1, 16'sd1, 16'sd1, 16'sd1);
      send_sample(16'sd1, 16'sd1, 16'sd1, 16'sd1);
      for (int i = 0; i < 4; i++) begin
         recv(d, l, ok);
         checks++;
         if (!ok || d !== 16'sd1 || l !== (i == 3)) begin
            errors++;
            $display("FAIL clear_out[%0d]: vld=%0b data=%0d last=%0b, required 1/%0b", i, ok, d, l, (i == 3));
         end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL clear_no_err: err=%0b, required 0", err);
      end
      send(16'sd0, 1'b0); send(16'sd0, 1'b1);
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_set: err=%0b, required 1", err);
      end
      send(16'sd0, 1'b0); send(16'sd0, 1'b1); send(16'sd0, 1'b0);
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_sticky: err=%0b, required 1", err);
      end
      @(negedge clk); clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      checks++;
      if (err !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%0b rdy=%0b vld=%0b, required 0/1/0", err, in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_drain;
      data_type d; logic l, ok;
      send_sample(16'sd2, 16'sd2, 16'sd2, 16'sd2);
      send_sample(16'sd2, 16'sd2, 16'sd2, 16'sd2);
      recv(d, l, ok);
      checks++;
      if (!ok || d !== 16'sd2) begin
         errors++; $display("FAIL rst_drain_first: data=%0d, required 2", d);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 16'sd0) begin
         errors++;
         $display("FAIL rst_drain_async: vld=%0b rdy=%0b data=%0d, required 0/0/0", out_valid, in_ready, out_data);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_drain_release: rdy=%0b vld=%0b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_single;
      data_type vals [4] = '{16'sd4, 16'sd4, 16'sd4, 16'sd5};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL single_ready[%0d]: rdy=%0b vld=%0b, required 1/0", i, in_ready2, out_valid2);
         end
         in_valid2 = 1'b1; in_data2 = vals[i]; in_last2 = 1'b1;
         @(posedge clk); #1 in_valid2 = 1'b0; in_last2 = 1'b0;
      end
      checks++;
      if (out_valid2 !== 1'b1 || out_data2 !== 16'sd4 || out_last2 !== 1'b1 || err2 !== 1'b0) begin
         errors++;
         $display("FAIL single_out: vld=%0b data=%0d last=%0b err=%0b, required 1/4/1/0",
                  out_valid2, out_data2, out_last2, err2);
      end
      @(negedge clk); out_ready2 = 1'b1;
      @(posedge clk); #1 out_ready2 = 1'b0;
      checks++;
      if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
         errors++;
         $display("FAIL single_done: vld=%0b rdy=%0b, required 0/1", out_valid2, in_ready2);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_floor;
      test_extremes;
      test_stall;
      test_clear;
      test_reset_mid_drain;
      test_single;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/grad_accumulator.md
# grad_accumulator

- Accumulates per-sample gradient streams over a mini-batch of 2^BATCH_LOG2 samples.
- Emits the batch-averaged gradient as an element stream. This is the producer end of the dW/db path that feeds the parameter update stage.
- One instance per parameter tensor (W1..W3, b1..b3). Elements are row-major, matching the update stage's [i][j] indexing.

## Interface
Parameters:
- M, 5, rows of the parameter tensor
- N, 3, columns of the parameter tensor (1 for bias vectors)
- BATCH_LOG2, 2, log2 of mini-batch size

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort of current batch
- in_valid  in  1  per-sample gradient element valid
- in_ready  out  1  accumulator accepts element
- in_data  in  data_type  per-sample gradient element
- in_last  in  1  marks element M*N-1 of a sample
- out_valid  out  1  averaged gradient element valid
- out_ready  in  1  update stage accepts element
- out_data  out  data_type  averaged gradient element
- out_last  out  1  marks element M*N-1 of the averaged tensor
- err  out  1  sticky framing error

## Operation
**Storage**
- Accumulator array of M*N entries, ACC_W = DATA_W + BATCH_LOG2 bits, signed. Never overflows.
- Counters: element index idx (0..M*N-1) and sample counter smp (0..2^BATCH_LOG2-1).

**States**
- ACCUM (reset state) and DRAIN.

**ACCUM**
- in_ready=1, out_valid=0.
- On each in_valid&&in_ready beat:
  - acc[idx] <= (smp==0) ? sext(in_data) : acc[idx]+sext(in_data).
  - idx increments, wrapping M*N-1 -> 0. On wrap, smp increments.
- Beat at idx==M*N-1 with smp==2^BATCH_LOG2-1: go to DRAIN with idx=0.

**DRAIN**
- in_ready=0, out_valid=1.
- out_data = acc[idx] >>> BATCH_LOG2 (arithmetic, floor), truncated to DATA_W. The result always fits.
- out_last = (idx==M*N-1).
- On each out_valid&&out_ready beat, idx increments.
- Beat with out_last: go to ACCUM with idx=0, smp=0.

**Framing**
- in_last is checked, not used for counting: err<=1 if in_last != (idx==M*N-1) on an accepted beat.
- err is cleared only by reset or clear.

**clear**
- Forces ACCUM, idx=0, smp=0, err=0.
- Has priority over any handshake in the same cycle; that beat is discarded.
- Accumulator contents need no reset: smp==0 overwrites them.

## Timing
**Reset values** (rst_n low): state=ACCUM, idx=0, smp=0, in_ready=0, out_valid=0, out_last=0, out_data=0, err=0. in_ready goes to 1 in the first cycle after rst_n deasserts.

**Throughput and latency**
- One element per cycle on each side.
- Minimum batch period is M*N*(2^BATCH_LOG2+1) cycles.
- Final input beat at edge t: out_valid=1 from t+1. The first element is readable without a bubble.

**Handshake**
- out_valid, out_data and out_last stay stable while out_valid&&!out_ready.
- in_ready does not depend on in_valid. out_valid does not depend on out_ready.

**Boundaries**
- DRAIN's last beat: in_ready is 1 in the next cycle.
- Reset mid-DRAIN: output drops immediately and the batch is lost.
- M*N==1: every accepted beat is a wrap and out_last is constantly 1 in DRAIN.

## Structure
- data_type, DATA_W and the layer sizes L1..L4 stay in the shared package/header.
- ACC_W is derived locally.
- Optional sub-module grad_acc_ctrl holds the FSM and counters (idx, smp). The datapath stays in grad_accumulator.
- The top-level network instantiates one grad_accumulator per W/b tensor, sized (L2,L1), (L3,L2), (L4,L3), (Lk,1).

## Test plan
Unless noted, all tests use M=2, N=2, BATCH_LOG2=1.

1. Samples [1,2,3,4] then [3,4,5,6] with out_ready=1 -> out_data 2,3,4,5; out_last only on 5; out_valid rises one cycle after the 8th input beat.
2. Samples [-3,-1,7,0] then [0,0,0,1] -> out_data -2,-1,3,0 (floor shift).
3. Both samples all elements 2^(DATA_W-1)-1, then both -2^(DATA_W-1) -> out_data equals that same extreme value (no wrap).
4. During DRAIN, hold out_ready=0 for 5 cycles -> out_data/out_last stable, in_ready=0; release -> remaining elements in order.
5. Pulse clear after 3 beats of sample 2, then feed two full samples [1,1,1,1] and [1,1,1,1] -> outputs 1,1,1,1 (the partial batch is discarded). Also: in_last asserted at idx=1 -> err=1 until clear.
6. Assert rst_n low in DRAIN mid-stream -> out_valid=0 asynchronously, in_ready=1 after release. Repeat with M=1, N=1, BATCH_LOG2=2 on inputs 4,4,4,5 -> out_data 4.
